// File: rtl/restador_pkg.sv
// ============================================================================
// Module : restador_pkg
// Brief  : Shared state encoding and counter sizing for the bit-serial subtractor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package restador_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit counter width; never below one bit so the counter always exists
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/restador_completo.sv
// ============================================================================
// Module : restador_completo
// Brief  : One-bit full subtractor, d = x - y - bi with borrow-out bo.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module restador_completo (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

`default_nettype wire

// File: rtl/restador_serie.sv
// ============================================================================
// Module : restador_serie
// Brief  : Bit-serial N-bit subtractor, diff = a - b - b_in, LSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module restador_serie
    import restador_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         overflow,
    output logic         zero
);

    localparam int                CNT_W      = cnt_width(N);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(N - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_sa;
    logic [N-1:0]     r_sb;
    logic [N-1:0]     r_sd;
    logic             r_bq;

    logic             w_d;
    logic             w_bo;
    logic [N-1:0]     w_sd_next;

    restador_completo u_completo (
        .x  (r_sa[0]),
        .y  (r_sb[0]),
        .bi (r_bq),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_sd_next = {w_d, r_sd[N-1:1]};

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sd     <= '0;
            r_bq     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_bq    <= b_in;
                        r_sd    <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sa  <= {1'b0, r_sa[N-1:1]};
                    r_sb  <= {1'b0, r_sb[N-1:1]};
                    r_sd  <= w_sd_next;
                    r_bq  <= w_bo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // MSB step: r_bq is the borrow into the MSB, w_bo the borrow out
                    if (r_cnt == C_CNT_LAST) begin
                        r_state  <= ST_DONE;
                        diff     <= w_sd_next;
                        borrow   <= w_bo;
                        overflow <= r_bq ^ w_bo;
                        zero     <= (w_sd_next == '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
